// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared widths, FSM states and requester ids for the memory port arbiter
package lc3_mem_pkg;
  localparam int AW = 16;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester ports, debug lock and memory-side bus of the arbiter
interface mem_port_arbiter_if;
  import lc3_mem_pkg::*;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_wait;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_lock;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_wait,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_ack, dbg_rdata,
    output mem_addr, mem_wdata, mem_we, busy,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_wait,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_ack, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we, busy,
    output mem_rdata
  );
endinterface

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - combinational two-way round-robin picker; ties go to the port not granted last
module mem_rr_pick
  import lc3_mem_pkg::*;
(
  input  logic [1:0] eligible,
  input  req_id_e    last_grant,
  output logic       grant_valid,
  output req_id_e    grant_id
);
  always_comb begin
    grant_valid = |eligible;
    grant_id    = REQ_CPU;
    if (eligible == 2'b11) begin
      grant_id = (last_grant == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (eligible[1]) begin
      grant_id = REQ_DBG;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises CPU and debug accesses to the single-port main memory
module mem_port_arbiter
  import lc3_mem_pkg::*;
(
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  state_e        state_q;
  req_id_e       id_q;
  req_id_e       last_grant_q;
  logic          we_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          cpu_ack_q;
  logic          dbg_ack_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;

  logic [1:0]    eligible;
  logic          grant_valid;
  req_id_e       grant_id;

  // A port whose ack is showing is still finishing its last access, so it sits out one arbitration.
  assign eligible[0] = bus.cpu_req & ~cpu_ack_q & ~bus.dbg_lock;
  assign eligible[1] = bus.dbg_req & ~dbg_ack_q;

  mem_rr_pick u_pick (
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      id_q         <= REQ_CPU;
      last_grant_q <= REQ_DBG;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            id_q    <= grant_id;
            state_q <= ACCESS;
            if (grant_id == REQ_CPU) begin
              we_q        <= bus.cpu_we;
              mem_we_q    <= bus.cpu_we;
              mem_addr_q  <= bus.cpu_addr;
              mem_wdata_q <= bus.cpu_wdata;
            end else begin
              we_q        <= bus.dbg_we;
              mem_we_q    <= bus.dbg_we;
              mem_addr_q  <= bus.dbg_addr;
              mem_wdata_q <= bus.dbg_wdata;
            end
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          state_q  <= RESP;
        end
        RESP: begin
          if (id_q == REQ_CPU) begin
            cpu_ack_q <= 1'b1;
            if (!we_q) cpu_rdata_q <= bus.mem_rdata;
          end else begin
            dbg_ack_q <= 1'b1;
            if (!we_q) dbg_rdata_q <= bus.mem_rdata;
          end
          last_grant_q <= id_q;
          state_q      <= IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.cpu_wait  = bus.cpu_req & ~cpu_ack_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import lc3_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  bit [15:0] mem     [0:65535];
  bit        written [0:65535];

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Registered-read memory; unwritten locations read a fixed pattern, 0x3000 holds 0xBEEF.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= written[bus.mem_addr] ? mem[bus.mem_addr] :
                     ((bus.mem_addr == 16'h3000) ? 16'hBEEF : (bus.mem_addr ^ 16'hA5A5));
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int wait_n, we_n, cpu_n, dbg_n, nowait_n, first_ack, cpu_at3;

  initial begin
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_wdata = 16'h0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 16'h0;
    bus.dbg_wdata = 16'h0;
    bus.dbg_lock  = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_mem_we",    16'(bus.mem_we),  16'd0);
    chk("rst_busy",      16'(bus.busy),    16'd0);
    chk("rst_cpu_ack",   16'(bus.cpu_ack), 16'd0);
    chk("rst_dbg_ack",   16'(bus.dbg_ack), 16'd0);
    chk("rst_mem_addr",  bus.mem_addr,     16'h0000);
    chk("rst_cpu_rdata", bus.cpu_rdata,    16'h0000);
    chk("rst_dbg_rdata", bus.dbg_rdata,    16'h0000);
    reset = 1'b1;
    @(negedge clk);

    // CPU read of 0x3000
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h3000;
    wait_n = 0;
    we_n   = 0;
    #1;
    if (bus.cpu_wait) wait_n++;
    @(negedge clk);
    chk("rd_access_addr", bus.mem_addr, 16'h3000);
    chk("rd_access_busy", 16'(bus.busy), 16'd1);
    if (bus.cpu_wait) wait_n++;
    if (bus.mem_we) we_n++;
    bus.cpu_addr = 16'h0123;
    @(negedge clk);
    chk("rd_resp_noack", 16'(bus.cpu_ack), 16'd0);
    if (bus.cpu_wait) wait_n++;
    if (bus.mem_we) we_n++;
    @(negedge clk);
    chk("rd_ack",       16'(bus.cpu_ack),  16'd1);
    chk("rd_rdata",     bus.cpu_rdata,     16'hBEEF);
    chk("rd_wait_low",  16'(bus.cpu_wait), 16'd0);
    if (bus.mem_we) we_n++;
    chk("rd_wait_cycles", 16'(wait_n), 16'd3);
    chk("rd_mem_we_cnt",  16'(we_n),   16'd0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("drop_ack_clear", 16'(bus.cpu_ack), 16'd0);
    chk("drop_busy",      16'(bus.busy),    16'd0);
    @(negedge clk);
    chk("drop_busy2",     16'(bus.busy),    16'd0);

    // Debug write 0x1234 to 0x0040, then CPU read back
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 16'h0040;
    bus.dbg_wdata = 16'h1234;
    @(negedge clk);
    chk("wr_mem_we",    16'(bus.mem_we), 16'd1);
    chk("wr_mem_addr",  bus.mem_addr,    16'h0040);
    chk("wr_mem_wdata", bus.mem_wdata,   16'h1234);
    @(negedge clk);
    chk("wr_mem_we_off", 16'(bus.mem_we), 16'd0);
    @(negedge clk);
    chk("wr_dbg_ack",   16'(bus.dbg_ack), 16'd1);
    chk("wr_dbg_rdata", bus.dbg_rdata,    16'h0000);
    bus.dbg_req  = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0040;
    repeat (2) @(negedge clk);
    chk("rb_noack_yet", 16'(bus.cpu_ack), 16'd0);
    @(negedge clk);
    chk("rb_ack",   16'(bus.cpu_ack), 16'd1);
    chk("rb_rdata", bus.cpu_rdata,    16'h1234);
    bus.cpu_req = 1'b0;

    // Both requesters active from reset: CPU first, then alternating
    reset         = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h3000;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 16'h0040;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cpu_n = 0;
    dbg_n = 0;
    first_ack = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        cpu_n++;
        if (first_ack == 0) first_ack = 1;
      end
      if (bus.dbg_ack) begin
        dbg_n++;
        if (first_ack == 0) first_ack = 2;
      end
    end
    chk("rr_cpu_acks",  16'(cpu_n),     16'd2);
    chk("rr_dbg_acks",  16'(dbg_n),     16'd2);
    chk("rr_first_cpu", 16'(first_ack), 16'd1);
    chk("rr_cpu_rdata", bus.cpu_rdata,  16'hBEEF);
    chk("rr_dbg_rdata", bus.dbg_rdata,  16'h1234);

    // Debug lock holds the CPU off
    bus.dbg_lock = 1'b1;
    cpu_n = 0;
    dbg_n = 0;
    nowait_n = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (bus.cpu_ack) cpu_n++;
      if (bus.dbg_ack) dbg_n++;
      if (!bus.cpu_wait) nowait_n++;
    end
    chk("lock_cpu_acks", 16'(cpu_n),    16'd0);
    chk("lock_dbg_acks", 16'(dbg_n),    16'd3);
    chk("lock_cpu_wait", 16'(nowait_n), 16'd0);
    bus.dbg_lock = 1'b0;
    dbg_n = 0;
    cpu_at3 = 0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (bus.dbg_ack) dbg_n++;
      if (j == 3 && bus.cpu_ack) cpu_at3 = 1;
    end
    chk("unlock_cpu_ack", 16'(cpu_at3), 16'd1);
    chk("unlock_no_dbg",  16'(dbg_n),   16'd0);

    // Reset during ACCESS of a write
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 16'h0050;
    bus.dbg_wdata = 16'h5555;
    @(negedge clk);
    chk("rstw_access_we", 16'(bus.mem_we), 16'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_mem_we",    16'(bus.mem_we),  16'd0);
    chk("rstw_busy",      16'(bus.busy),    16'd0);
    chk("rstw_dbg_ack",   16'(bus.dbg_ack), 16'd0);
    chk("rstw_cpu_ack",   16'(bus.cpu_ack), 16'd0);
    chk("rstw_mem_addr",  bus.mem_addr,     16'h0000);
    chk("rstw_mem_wdata", bus.mem_wdata,    16'h0000);
    chk("rstw_cpu_rdata", bus.cpu_rdata,    16'h0000);
    chk("rstw_dbg_rdata", bus.dbg_rdata,    16'h0000);
    bus.dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dbg_n = 0;
    nowait_n = 0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (bus.dbg_ack || bus.cpu_ack) dbg_n++;
      if (bus.busy || bus.mem_we) nowait_n++;
    end
    chk("rstw_no_ack",  16'(dbg_n),    16'd0);
    chk("rstw_no_busy", 16'(nowait_n), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
